inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the non-pipelined RISC-V core. It sits directly upstream of the instruction decoder/controller. It owns the program counter, fetches one 32-bit word at a time from instruction memory over a req/gnt/rvalid handshake, and presents it as `inst` with `inst_valid`. It then holds that instruction until the core signals retirement, and uses the controller's `PCSel` plus the ALU result to choose the next PC.

## Interface
Parameters:
- `XLEN`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `imem_req` out 1: fetch request, held until granted
- `imem_addr` out XLEN: word address of the fetch, equals `pc`
- `imem_gnt` in 1: memory accepted the request
- `imem_rvalid` in 1: read data valid
- `imem_rdata` in 32: instruction word
- `inst` out 32: registered instruction to the controller
- `inst_valid` out 1: `inst` is the word at `pc`
- `pc` out XLEN: current PC
- `pc_plus4` out XLEN: `pc + 4`, for JAL/JALR link writeback
- `retire` in 1: the current instruction has completed this cycle
- `PCSel` in 1: from the controller; 1 = take `alu_result` as the next PC
- `alu_result` in XLEN: branch/jump target
- `fetch_fault` out 1: misaligned target trap (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: `imem_req`=0. Always moves to REQ on the next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`, go to WAIT. Otherwise stay, keeping the address stable.
- WAIT: on `imem_rvalid`, capture `imem_rdata` into `inst` and go to HOLD.
- HOLD: `inst_valid`=1.
  - On `retire`, load `pc` with the next PC and go to REQ.
  - Next PC is `{alu_result[XLEN-1:2],2'b00}` if `PCSel`, else `pc+4`.
- FAULT: terminal until reset. `imem_req`=0, `inst_valid`=0, `fetch_fault`=1.
- `retire` outside HOLD is ignored.
- `imem_rvalid` outside WAIT is ignored; the memory guarantees rvalid no earlier than the cycle after gnt.
- `imem_gnt` outside REQ is ignored.
- `inst` holds its last captured value outside HOLD. `inst_valid` is the only qualifier.
- `pc+4` wraps modulo 2^XLEN: 32'hFFFF_FFFC goes to 32'h0000_0000.
- `PCSel` is sampled only in the `retire` cycle.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - state = IDLE, `pc` = RESET_PC, `inst` = 32'h0000_0013 (NOP)
  - `inst_valid`=0, `imem_req`=0, `fetch_fault`=0
- Reset mid-transaction (REQ/WAIT/HOLD) aborts the fetch. Any rvalid arriving after reset is ignored, since the state is no longer WAIT.
- `imem_req` and `inst_valid` are decoded from registered state: no combinational path from inputs.
- Minimum fetch latency, with cycle 0 = first cycle after reset release (IDLE):
  - cycle 1: REQ, with gnt in the same cycle
  - cycle 2: WAIT, with rvalid
  - cycle 3: HOLD, `inst_valid`=1
- Retire in HOLD at cycle N: new `pc` visible at N+1 with `imem_req`=1. The earliest next `inst_valid` is N+3.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - A retire with `PCSel`=1 and `alu_result[1:0]`≠0 loads `pc` with the unmodified `alu_result` and enters FAULT.
  - `fetch_fault` is a sticky 1 until reset.
- `IFETCH_MISALIGN_TRAP_EN` undefined:
  - Target bits [1:0] are silently cleared.
  - The FAULT state is not compiled in.
  - `fetch_fault` is tied to 0.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t`
  - `INST_NOP` = 32'h0000_0013
  - default `RESET_PC`
- One sub-module, `next_pc_mux`: combinational selection of `pc+4` vs the aligned target, plus the misalignment detect output.

## Test plan
- Reset release, memory grants immediately with rvalid next cycle:
  - `imem_req` rises cycle 1 with `imem_addr`=0.
  - `inst_valid` rises cycle 3 with `inst`=rdata.
  - `pc_plus4`=4.
- gnt withheld 3 cycles in REQ → `imem_req` stays 1 and `imem_addr` stays stable all 4 cycles. `inst_valid` stays 0.
- HOLD at pc=0x100:
  - retire with `PCSel`=0 → next `imem_addr`=0x104.
  - retire with `PCSel`=1, `alu_result`=0x200 → next `imem_addr`=0x200.
- `pc`=32'hFFFF_FFFC, retire with `PCSel`=0 → next `imem_addr`=0.
- `alu_result`=0x203 with `PCSel`=1 on retire:
  - With the macro: FAULT, `fetch_fault`=1, no further `imem_req`.
  - Without the macro: `imem_addr`=0x200.
- `rst_n` low in WAIT, with rvalid arriving during the first post-reset cycle → rdata not captured. `inst`=NOP, `inst_valid`=0, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IFETCH_MISALIGN_TRAP_EN adds the FAULT state for misaligned jump/branch targets.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
`ifdef IFETCH_MISALIGN_TRAP_EN
    ST_HOLD,
    ST_FAULT
`else
    ST_HOLD
`endif
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: sequential pc+4 or word-aligned ALU target, plus misalignment detect.
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Sequential successor wraps naturally modulo 2^XLEN.
  assign pc_plus4   = pc + XLEN'(4);
  assign next_pc    = pc_sel ? {alu_result[XLEN-1:2], 2'b00} : pc_plus4;
  assign misaligned = pc_sel & (|alu_result[1:0]);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word over req/gnt/rvalid, holds it until retire.
// IFETCH_MISALIGN_TRAP_EN: misaligned taken targets enter a sticky FAULT state instead of being aligned.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            retire,
  input  logic            PCSel,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_fault
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     inst_nxt;
  logic            target_misaligned;

  next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
    .pc         (pc),
    .pc_sel     (PCSel),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (target_misaligned)
  );

  assign imem_addr = pc;

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (imem_gnt) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          inst_nxt  = imem_rdata;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (target_misaligned) begin
            pc_nxt    = alu_result;
            state_nxt = ST_FAULT;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = ST_REQ;
          end
`else
          pc_nxt    = next_pc;
          state_nxt = ST_REQ;
`endif
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      ST_FAULT: state_nxt = ST_FAULT;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; handshake qualifiers are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      inst       <= INST_NOP;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_valid <= (state_nxt == ST_HOLD);
      imem_req   <= (state_nxt == ST_REQ);
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) fetch_fault <= 1'b0;
    else        fetch_fault <= (state_nxt == ST_FAULT);
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = target_misaligned;
  assign fetch_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes expected fetch addresses and instructions,
// a negedge monitor pops them on each granted request and each rising inst_valid.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        PCSel;
  logic [31:0] alu_result;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .PCSel       (PCSel),
    .alu_result  (alu_result),
    .fetch_fault (fetch_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare granted request addresses and newly valid instructions against the scoreboard.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && imem_req && imem_gnt) begin
      if (exp_addr_q.size() == 0) check("unexpected_req", imem_addr, 32'hxxxx_xxxx);
      else check("req_addr", imem_addr, exp_addr_q.pop_front());
    end
    if (inst_valid && !valid_prev) begin
      if (exp_inst_q.size() == 0) check("unexpected_inst", inst, 32'hxxxx_xxxx);
      else begin
        e = exp_inst_q.pop_front();
        check("inst_word", inst, e[63:32]);
        check("inst_pc", pc, e[31:0]);
      end
    end
    valid_prev <= inst_valid;
  end

  task automatic do_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    retire = 1'b0; PCSel = 1'b0; alu_result = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Complete one fetch from the current point; gnt withheld for hold_gnt REQ cycles.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int hold_gnt,
                       output int lat);
    int n;
    logic [31:0] a0;
    exp_addr_q.push_back(addr);
    exp_inst_q.push_back({rdata, addr});
    lat = 0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1; n++; lat++;
    end
    if (!imem_req) check("req_timeout", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    for (int i = 0; i < hold_gnt; i++) begin
      @(posedge clk); #1; lat++;
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, a0);
      check("stall_valid", 32'(inst_valid), 32'd0);
    end
    imem_gnt = 1'b1;
    @(posedge clk); #1; lat++;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = rdata;
    @(posedge clk); #1; lat++;
    imem_rvalid = 1'b0;
  endtask

  task automatic do_retire(input logic sel, input logic [31:0] tgt);
    retire = 1'b1; PCSel = sel; alu_result = tgt;
    @(posedge clk); #1;
    retire = 1'b0; PCSel = 1'b0; alu_result = 32'h0;
  endtask

  initial begin
    int lat;
    do_reset();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    fetch(32'h0, 32'h0010_0093, 0, lat);
    check("min_latency", 32'(lat), 32'd3);
    check("valid_c3", 32'(inst_valid), 32'd1);
    check("pc_plus4_0", pc_plus4, 32'h4);

    do_retire(1'b0, 32'hFFFF_FFFF);
    check("req_after_retire", 32'(imem_req), 32'd1);
    fetch(32'h4, 32'h0020_0113, 3, lat);

    do_retire(1'b1, 32'h100);
    fetch(32'h100, 32'h0030_0193, 0, lat);
    do_retire(1'b0, 32'h0);
    fetch(32'h104, 32'h0040_0213, 0, lat);
    check("pc_plus4_104", pc_plus4, 32'h108);
    do_retire(1'b1, 32'h200);
    fetch(32'h200, 32'h0050_0293, 0, lat);
    do_retire(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0060_0313, 0, lat);
    check("pc_plus4_wrap", pc_plus4, 32'h0);
    do_retire(1'b0, 32'h0);
    fetch(32'h0, 32'h0070_0393, 0, lat);

    do_retire(1'b1, 32'h203);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_pc", pc, 32'h203);
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1;
      @(posedge clk); #1;
      check("fault_no_req", 32'(imem_req), 32'd0);
      check("fault_sticky", 32'(fetch_fault), 32'd1);
    end
    imem_gnt = 1'b0;
`else
    check("no_fault", 32'(fetch_fault), 32'd0);
    fetch(32'h200, 32'h0080_0413, 0, lat);
`endif

    // Reset while waiting for rvalid; late rvalid must be dropped.
    do_reset();
    exp_addr_q.push_back(32'h0);
    @(posedge clk); #1;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    check("abort_inst", inst, 32'h0000_0013);
    check("abort_valid", 32'(inst_valid), 32'd0);
    check("abort_req", 32'(imem_req), 32'd1);
    check("abort_addr", imem_addr, 32'h0);
    fetch(32'h0, 32'h0090_0493, 0, lat);

    repeat (3) @(posedge clk);
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
